// File: rtl/fft_inpl_frame_feeder_pkg.sv
// fft_inpl_frame_feeder_pkg: frame-state encoding and width helper shared by the feeder files
package fft_inpl_frame_feeder_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DROP} frame_state_e;

  function automatic int ceil_log2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fft_inpl_feeder_fifo.sv
// fft_inpl_feeder_fifo: register-array FIFO with level, full and empty flags
module fft_inpl_feeder_fifo
  import fft_inpl_frame_feeder_pkg::*;
#(
  parameter int DW    = 36,
  parameter int DEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [DW-1:0]             wr_data_i,
  input  logic                      rd_en_i,
  output logic [DW-1:0]             rd_data_o,
  output logic [ceil_log2(DEPTH):0] level_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int AW = ceil_log2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;

  // Storage carries no reset; the level gates every read of it.
  always_ff @(posedge clk_i)
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, wr_en_i} - {{AW{1'b0}}, rd_en_i};
    end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign full_o    = level_q == (AW+1)'(DEPTH);
  assign empty_o   = level_q == '0;

endmodule

// File: rtl/fft_inpl_frame_feeder.sv
// fft_inpl_frame_feeder: buffers an upstream sample stream and loads the FFT core in
// POINTS-sample frames, discarding the tail of any frame the core aborts.
module fft_inpl_frame_feeder
  import fft_inpl_frame_feeder_pkg::*;
#(
  parameter int POINTS     = 256,
  parameter int WIDTH      = 18,
  parameter int FIFO_DEPTH = 16,
  parameter int CNTW       = 16
) (
  input  logic                           CLK,
  input  logic                           NGRST,
  input  logic                           S_VALID,
  output logic                           S_READY,
  input  logic [WIDTH-1:0]               S_RE,
  input  logic [WIDTH-1:0]               S_IM,
  input  logic                           BUF_READY,
  output logic                           DATAI_VALID,
  output logic [WIDTH-1:0]               DATAI_RE,
  output logic [WIDTH-1:0]               DATAI_IM,
  output logic                           FRAME_START,
  output logic                           FRAME_DONE,
  output logic                           FRAME_ERR,
  output logic [CNTW-1:0]                FRAME_CNT,
  output logic [ceil_log2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int            PW   = ceil_log2(POINTS);
  localparam logic [PW-1:0] LAST = PW'(POINTS - 1);

  frame_state_e       state_q, state_d;
  logic [PW-1:0]      cnt_q, cnt_d, rem_q, rem_d;
  logic [CNTW-1:0]    fcnt_q, fcnt_d;
  logic [2*WIDTH-1:0] rd_data;
  logic               full, empty, push, pop, deliver, last, err;
  logic               dv_q, fs_q, fd_q, fe_q;
  logic [WIDTH-1:0]   re_q, im_q;

  fft_inpl_feeder_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (NGRST),
    .wr_en_i   (push),
    .wr_data_i ({S_RE, S_IM}),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .level_o   (FIFO_LEVEL),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign deliver = state_q != DROP && BUF_READY && !empty;
  assign last    = deliver && cnt_q == LAST;
  assign S_READY = state_q == DROP || !full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    fcnt_d  = fcnt_q;
    push    = S_VALID && !full;
    pop     = deliver;
    err     = 1'b0;
    case (state_q)
      IDLE: if (BUF_READY) state_d = LOAD;
      LOAD: if (!BUF_READY) begin
        err     = cnt_q != '0;
        state_d = err ? DROP : IDLE;
        rem_d   = PW'(POINTS) - cnt_q;
        cnt_d   = '0;
      end
      DROP: begin
        // Buffered samples are discarded before upstream ones; upstream keeps filling behind them.
        pop  = !empty;
        push = S_VALID && !empty;
        if (S_VALID || !empty) begin
          rem_d   = rem_q - 1'b1;
          state_d = rem_q == PW'(1) ? IDLE : DROP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (deliver) cnt_d = cnt_q + 1'b1;
    if (last) begin
      state_d = IDLE;
      fcnt_d  = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge NGRST)
    if (!NGRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      fcnt_q  <= '0;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      fe_q    <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      fcnt_q  <= fcnt_d;
      dv_q    <= deliver;
      fs_q    <= deliver && cnt_q == '0;
      fd_q    <= last;
      fe_q    <= err;
      if (deliver) {re_q, im_q} <= rd_data;
    end

  assign DATAI_VALID = dv_q;
  assign DATAI_RE    = re_q;
  assign DATAI_IM    = im_q;
  assign FRAME_START = fs_q;
  assign FRAME_DONE  = fd_q;
  assign FRAME_ERR   = fe_q;
  assign FRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_fft_inpl_frame_feeder.sv
// tb_fft_inpl_frame_feeder: random-data scenarios checked against a stream-level frame model
module tb_fft_inpl_frame_feeder;

  localparam int P = 16, W = 18, D = 16, CW = 2, LW = 5;

  typedef struct packed {
    logic [2*W-1:0] d;
    logic           fs;
    logic           fd;
    logic [CW-1:0]  fc;
  } obs_t;

  logic          CLK = 1'b0, NGRST = 1'b0, S_VALID = 1'b0, BUF_READY = 1'b0;
  logic [W-1:0]  S_RE = '0, S_IM = '0;
  logic          S_READY, DATAI_VALID, FRAME_START, FRAME_DONE, FRAME_ERR;
  logic [W-1:0]  DATAI_RE, DATAI_IM;
  logic [CW-1:0] FRAME_CNT;
  logic [LW-1:0] FIFO_LEVEL;

  int             checks = 0, fails = 0, cyc_n = 0, errs = 0, err_t = 0;
  logic [CW-1:0]  fc_m = '0;
  logic [2*W-1:0] sent[$];
  int             sent_t[$];
  obs_t           got[$];
  int             got_t[$];

  fft_inpl_frame_feeder #(
    .POINTS     (P),
    .WIDTH      (W),
    .FIFO_DEPTH (D),
    .CNTW       (CW)
  ) dut (
    .CLK         (CLK),
    .NGRST       (NGRST),
    .S_VALID     (S_VALID),
    .S_READY     (S_READY),
    .S_RE        (S_RE),
    .S_IM        (S_IM),
    .BUF_READY   (BUF_READY),
    .DATAI_VALID (DATAI_VALID),
    .DATAI_RE    (DATAI_RE),
    .DATAI_IM    (DATAI_IM),
    .FRAME_START (FRAME_START),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_ERR   (FRAME_ERR),
    .FRAME_CNT   (FRAME_CNT),
    .FIFO_LEVEL  (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  // Accepted upstream samples and delivered core samples, both sampled mid-cycle.
  always @(negedge CLK)
    if (NGRST) begin
      if (S_VALID && S_READY) begin
        sent.push_back({S_RE, S_IM});
        sent_t.push_back(cyc_n);
      end
      if (DATAI_VALID) begin
        got.push_back('{d: {DATAI_RE, DATAI_IM}, fs: FRAME_START, fd: FRAME_DONE, fc: FRAME_CNT});
        got_t.push_back(cyc_n);
      end
      if (FRAME_ERR) begin
        errs  <= errs + 1;
        err_t <= cyc_n;
      end
    end

  // Expected delivery of accepted sample src at position pos of its frame.
  function automatic obs_t exp_obs(input int src, input int pos, input logic [CW-1:0] fc);
    obs_t o;
    o.d  = src < sent.size() ? sent[src] : 'x;
    o.fs = pos == 0;
    o.fd = pos == P-1;
    o.fc = pos == P-1 ? fc + 1'b1 : fc;
    return o;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_sb();
    sent.delete();
    sent_t.delete();
    got.delete();
    got_t.delete();
    errs = 0;
  endtask

  task automatic push_n(input int n, input bit gaps);
    int k = 0;
    for (int g = 0; g < 400 && k < n; g++) begin
      S_RE    = W'($urandom);
      S_IM    = W'($urandom);
      S_VALID = 1'b1;
      @(negedge CLK);
      if (S_READY) k++;
      cyc();
      if (gaps) begin
        S_VALID = 1'b0;
        cyc();
      end
    end
    S_VALID = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 300 && got.size() < n; i++) @(posedge CLK);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    checks++;
    if ({DATAI_VALID, FRAME_START, FRAME_DONE, FRAME_ERR} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {DATAI_VALID, FRAME_START, FRAME_DONE, FRAME_ERR});
    checks++;
    if ({DATAI_RE, DATAI_IM} !== '0) $display("FAIL reset_data: got %h expected 0", {DATAI_RE, DATAI_IM});
    checks++;
    if (FRAME_CNT !== '0) $display("FAIL reset_cnt: got %0d expected 0", FRAME_CNT);
    checks++;
    if (FIFO_LEVEL !== '0) $display("FAIL reset_level: got %0d expected 0", FIFO_LEVEL);
    fails += int'({DATAI_VALID, FRAME_START, FRAME_DONE, FRAME_ERR} !== 4'b0)
           + int'({DATAI_RE, DATAI_IM} !== '0) + int'(FRAME_CNT !== '0) + int'(FIFO_LEVEL !== '0);
    NGRST = 1'b1;
    cyc();
    checks++;
    if (S_READY !== 1'b1) begin
      fails++;
      $display("FAIL reset_sready: got %b expected 1", S_READY);
    end
  endtask

  task automatic test_continuous();
    clear_sb();
    BUF_READY = 1'b1;
    push_n(P, 1'b0);
    wait_got(P);
    checks++;
    if (got.size() != P) begin
      fails++;
      $display("FAIL cont_count: got %0d expected %0d", got.size(), P);
    end
    for (int i = 0; i < P && i < got.size(); i++) begin
      obs_t e = exp_obs(i, i, fc_m);
      checks++;
      if (got[i] !== e) begin
        fails++;
        $display("FAIL cont_sample[%0d]: got %h expected %h", i, got[i], e);
      end
    end
    fc_m = fc_m + 1'b1;
    checks++;
    if (got_t.size() < P || got_t[P-1] - got_t[0] != P-1) begin
      fails++;
      $display("FAIL cont_contiguous: got %0d samples not back to back, expected %0d", got_t.size(), P);
    end
    checks++;
    if (got_t.size() < 1 || sent_t.size() < 1 || got_t[0] - sent_t[0] != 2) begin
      fails++;
      $display("FAIL cont_latency: got %0d expected 2", got_t.size() > 0 && sent_t.size() > 0 ? got_t[0] - sent_t[0] : -1);
    end
    checks++;
    if (FRAME_CNT !== 2'd1) begin
      fails++;
      $display("FAIL cont_frame_cnt: got %0d expected 1", FRAME_CNT);
    end
    BUF_READY = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_gaps();
    clear_sb();
    BUF_READY = 1'b1;
    push_n(P, 1'b1);
    wait_got(P);
    checks++;
    if (got.size() != P) begin
      fails++;
      $display("FAIL gaps_count: got %0d expected %0d", got.size(), P);
    end
    for (int i = 0; i < P && i < got.size(); i++) begin
      obs_t e = exp_obs(i, i, fc_m);
      checks++;
      if (got[i] !== e) begin
        fails++;
        $display("FAIL gaps_sample[%0d]: got %h expected %h", i, got[i], e);
      end
    end
    fc_m = fc_m + 1'b1;
    checks++;
    if (got_t.size() < P || got_t[P-1] - got_t[0] <= P-1) begin
      fails++;
      $display("FAIL gaps_spread: got span below %0d expected gaps", P);
    end
    checks++;
    if (errs != 0) begin
      fails++;
      $display("FAIL gaps_err: got %0d expected 0", errs);
    end
    BUF_READY = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_backpressure();
    clear_sb();
    BUF_READY = 1'b0;
    S_VALID   = 1'b1;
    repeat (20) begin
      S_RE = W'($urandom);
      S_IM = W'($urandom);
      cyc();
    end
    S_VALID = 1'b0;
    checks++;
    if (sent.size() != D) begin
      fails++;
      $display("FAIL bp_accepted: got %0d expected %0d", sent.size(), D);
    end
    checks++;
    if (sent_t.size() < D || sent_t[D-1] - sent_t[0] != D-1) begin
      fails++;
      $display("FAIL bp_first_accepts: got %0d not consecutive expected %0d", sent_t.size(), D);
    end
    checks++;
    if (FIFO_LEVEL !== LW'(D)) begin
      fails++;
      $display("FAIL bp_level: got %0d expected %0d", FIFO_LEVEL, D);
    end
    checks++;
    if (S_READY !== 1'b0) begin
      fails++;
      $display("FAIL bp_sready: got %b expected 0", S_READY);
    end
    BUF_READY = 1'b1;
    push_n(P, 1'b0);
    wait_got(2*P);
    checks++;
    if (got.size() != 2*P) begin
      fails++;
      $display("FAIL bp_count: got %0d expected %0d", got.size(), 2*P);
    end
    for (int i = 0; i < 2*P && i < got.size(); i++) begin
      obs_t e = exp_obs(i, i % P, fc_m);
      checks++;
      if (got[i] !== e) begin
        fails++;
        $display("FAIL bp_sample[%0d]: got %h expected %h", i, got[i], e);
      end
      if (i % P == P-1) fc_m = fc_m + 1'b1;
    end
    BUF_READY = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_abort();
    int drop_c;
    clear_sb();
    BUF_READY = 1'b0;
    push_n(8, 1'b0);
    BUF_READY = 1'b1;
    repeat (5) cyc();
    BUF_READY = 1'b0;
    drop_c    = cyc_n;
    repeat (3) cyc();
    checks++;
    if (errs != 1) begin
      fails++;
      $display("FAIL abort_err_count: got %0d expected 1", errs);
    end
    checks++;
    if (err_t != drop_c + 1) begin
      fails++;
      $display("FAIL abort_err_cycle: got %0d expected %0d", err_t, drop_c + 1);
    end
    BUF_READY = 1'b1;
    push_n(8 + P, 1'b0);
    wait_got(5 + P);
    checks++;
    if (got.size() != 5 + P) begin
      fails++;
      $display("FAIL abort_count: got %0d expected %0d", got.size(), 5 + P);
    end
    for (int i = 0; i < 5 + P && i < got.size(); i++) begin
      obs_t e = i < 5 ? exp_obs(i, i, fc_m) : exp_obs(P + i - 5, i - 5, fc_m);
      checks++;
      if (got[i] !== e) begin
        fails++;
        $display("FAIL abort_sample[%0d]: got %h expected %h", i, got[i], e);
      end
    end
    fc_m = fc_m + 1'b1;
    checks++;
    if (errs != 1) begin
      fails++;
      $display("FAIL abort_err_after: got %0d expected 1", errs);
    end
    BUF_READY = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_boundary();
    clear_sb();
    BUF_READY = 1'b0;
    push_n(P, 1'b0);
    BUF_READY = 1'b1;
    repeat (P) cyc();
    BUF_READY = 1'b0;
    wait_got(P);
    checks++;
    if (got.size() != P) begin
      fails++;
      $display("FAIL bound_count: got %0d expected %0d", got.size(), P);
    end
    for (int i = 0; i < P && i < got.size(); i++) begin
      obs_t e = exp_obs(i, i, fc_m);
      checks++;
      if (got[i] !== e) begin
        fails++;
        $display("FAIL bound_sample[%0d]: got %h expected %h", i, got[i], e);
      end
    end
    fc_m = fc_m + 1'b1;
    checks++;
    if (errs != 0) begin
      fails++;
      $display("FAIL bound_err: got %0d expected 0", errs);
    end
    checks++;
    if (FRAME_CNT !== fc_m) begin
      fails++;
      $display("FAIL bound_frame_cnt: got %0d expected %0d", FRAME_CNT, fc_m);
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    BUF_READY = 1'b1;
    push_n(2*P, 1'b0);
    wait_got(2*P);
    checks++;
    if (got.size() != 2*P) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected %0d", got.size(), 2*P);
    end
    for (int i = 0; i < 2*P && i < got.size(); i++) begin
      obs_t e = exp_obs(i, i % P, fc_m);
      checks++;
      if (got[i] !== e) begin
        fails++;
        $display("FAIL b2b_sample[%0d]: got %h expected %h", i, got[i], e);
      end
      if (i % P == P-1) fc_m = fc_m + 1'b1;
    end
    checks++;
    if (got_t.size() < 2*P || got_t[2*P-1] - got_t[0] != 2*P-1) begin
      fails++;
      $display("FAIL b2b_contiguous: got %0d samples not back to back, expected %0d", got_t.size(), 2*P);
    end
    checks++;
    if (FRAME_CNT !== fc_m) begin
      fails++;
      $display("FAIL b2b_wrap_cnt: got %0d expected %0d", FRAME_CNT, fc_m);
    end
    checks++;
    if (errs != 0) begin
      fails++;
      $display("FAIL b2b_err: got %0d expected 0", errs);
    end
    BUF_READY = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_reset_midframe();
    clear_sb();
    BUF_READY = 1'b1;
    push_n(7, 1'b0);
    checks++;
    if (DATAI_VALID !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre_valid: got %b expected 1", DATAI_VALID);
    end
    #2;
    NGRST = 1'b0;
    #1;
    checks++;
    if ({DATAI_VALID, FRAME_START, FRAME_DONE, FRAME_ERR} !== 4'b0) begin
      fails++;
      $display("FAIL mid_flags: got %b expected 0000", {DATAI_VALID, FRAME_START, FRAME_DONE, FRAME_ERR});
    end
    checks++;
    if ({DATAI_RE, DATAI_IM, FRAME_CNT, FIFO_LEVEL} !== '0) begin
      fails++;
      $display("FAIL mid_regs: got %h expected 0", {DATAI_RE, DATAI_IM, FRAME_CNT, FIFO_LEVEL});
    end
    repeat (2) cyc();
    NGRST = 1'b1;
    fc_m  = '0;
    clear_sb();
    push_n(P, 1'b0);
    wait_got(P);
    checks++;
    if (got.size() != P) begin
      fails++;
      $display("FAIL mid_count: got %0d expected %0d", got.size(), P);
    end
    for (int i = 0; i < P && i < got.size(); i++) begin
      obs_t e = exp_obs(i, i, fc_m);
      checks++;
      if (got[i] !== e) begin
        fails++;
        $display("FAIL mid_sample[%0d]: got %h expected %h", i, got[i], e);
      end
    end
    checks++;
    if (errs != 0) begin
      fails++;
      $display("FAIL mid_err: got %0d expected 0", errs);
    end
    BUF_READY = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_backpressure();
    test_abort();
    test_boundary();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
